// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if: ROM read port plus the valid/ready word stream.
// master = the reader, slave = the ROM/consumer side.
interface rom_stream_reader_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              rom_enb;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        output rom_enb, rom_addr, m_valid, m_data, m_last,
        input  rom_data, m_ready
    );

    modport slave (
        input  rom_enb, rom_addr, m_valid, m_data, m_last,
        output rom_data, m_ready
    );
endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a ROM address window and streams each word out.
// One word in flight at a time: fetch, capture, then hold until accepted.
module rom_stream_reader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     len,
    rom_stream_reader_if.master bus,
    output logic                busy,
    output logic                done
);
    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, FINISH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   cnt_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q, last_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (len == '0) ? FINISH : FETCH;
            FETCH:   state_d = CAPTURE;
            CAPTURE: state_d = SEND;
            SEND:    if (bus.m_ready) state_d = last_q ? FINISH : FETCH;
            default: state_d = IDLE;
        endcase
    end

    // ROM data is registered, so it is valid during CAPTURE and latched at its end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                addr_q <= base_addr;
                cnt_q  <= len;
            end
            if (state_q == CAPTURE) begin
                data_q  <= bus.rom_data;
                last_q  <= cnt_q == (ADDR_W+1)'(1);
                valid_q <= 1'b1;
            end
            if (state_q == SEND && bus.m_ready) begin
                valid_q <= 1'b0;
                cnt_q   <= cnt_q - 1'b1;
                if (!last_q) addr_q <= addr_q + 1'b1;
            end
        end

    assign bus.rom_enb  = state_q == FETCH;
    assign bus.rom_addr = addr_q;
    assign bus.m_valid  = valid_q;
    assign bus.m_data   = data_q;
    assign bus.m_last   = last_q;
    assign busy         = state_q != IDLE;
    assign done         = state_q == FINISH;
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: directed bursts against an 8x8 ROM model, with a
// per-cycle scoreboard plus literal per-test expectations.
module tb_rom_stream_reader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] base_addr = '0;
    logic [3:0] len = '0;
    logic       busy, done;
    logic       m_ready = 1'b0;

    rom_stream_reader_if #(.ADDR_W(3), .DATA_W(8)) bus ();
    assign bus.m_ready = m_ready;

    rom_stream_reader #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .len(len), .bus(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [8] = '{8'h01, 8'hAA, 8'h54, 8'hFA, 8'hE5, 8'h98, 8'h56, 8'h34};

    always @(posedge clk) if (bus.rom_enb) bus.rom_data <= mem[bus.rom_addr];

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // scoreboard: every word/address a started burst must produce, in order
    logic [7:0] exp_d [$];
    logic       exp_l [$];
    logic [2:0] exp_a [$];

    task automatic push_model(input logic [2:0] b, input logic [3:0] l);
        logic [2:0] a;
        for (int i = 0; i < int'(l); i++) begin
            a = b + 3'(i);
            exp_a.push_back(a);
            exp_d.push_back(mem[a]);
            exp_l.push_back(i == int'(l) - 1);
        end
    endtask

    logic       prev_stall = 1'b0;
    logic [8:0] prev_w = '0;

    always begin
        @(negedge clk);
        #3;
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", 64'(bus.m_valid), 64'(1));
                chk("hold_word", 64'({bus.m_last, bus.m_data}), 64'(prev_w));
            end
            if (bus.rom_enb) begin
                chk("enb_while_valid", 64'(bus.m_valid), 64'(0));
                if (exp_a.size() > 0) chk("rom_addr", 64'(bus.rom_addr), 64'(exp_a.pop_front()));
                else begin
                    checks++; failures++;
                    $display("FAIL rom_enb: got unexpected read at %0h expected none", bus.rom_addr);
                end
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_d.size() > 0) begin
                    chk("m_data", 64'(bus.m_data), 64'(exp_d.pop_front()));
                    chk("m_last", 64'(bus.m_last), 64'(exp_l.pop_front()));
                end else begin
                    checks++; failures++;
                    $display("FAIL m_valid: got unexpected word %0h expected none", bus.m_data);
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_w = {bus.m_last, bus.m_data};
        end else prev_stall = 1'b0;
    end

    // per-burst observations, measured in negedges after the start edge
    logic [7:0] log_d [$];
    logic       log_l [$];
    logic [2:0] log_a [$];
    int         hs_n [$];
    int         first_v, busy_n, dones, done_n, n_enb;

    function automatic logic [63:0] pk_d();
        logic [63:0] v = '0;
        foreach (log_d[i]) v = {v[55:0], log_d[i]};
        return v;
    endfunction

    function automatic logic [63:0] pk_l();
        logic [63:0] v = '0;
        foreach (log_l[i]) v = {v[62:0], log_l[i]};
        return v;
    endfunction

    function automatic logic [63:0] pk_a();
        logic [63:0] v = '0;
        foreach (log_a[i]) v = {v[59:0], 1'b0, log_a[i]};
        return v;
    endfunction

    function automatic logic [63:0] pk_g();
        logic [63:0] v = '0;
        for (int i = 1; i < hs_n.size(); i++) v = {v[59:0], 4'(hs_n[i] - hs_n[i-1])};
        return v;
    endfunction

    task automatic burst(input logic [2:0] b, input logic [3:0] l, input int stall, input bit spur);
        int seen = 0;
        log_d.delete(); log_l.delete(); log_a.delete(); hs_n.delete();
        first_v = -1; busy_n = 0; dones = 0; done_n = -1; n_enb = 0;
        @(negedge clk); #1;
        start = 1'b1; base_addr = b; len = l; m_ready = stall == 0;
        push_model(b, l);
        for (int n = 1; n < 200; n++) begin
            @(negedge clk); #1;
            start = spur && n == 4;
            base_addr = (spur && n == 4) ? 3'd3 : b;
            len = (spur && n == 4) ? 4'd1 : l;
            if (busy) busy_n++;
            if (done) begin dones++; done_n = n; end
            if (bus.rom_enb) begin n_enb++; log_a.push_back(bus.rom_addr); end
            if (bus.m_valid && first_v < 0) first_v = n;
            if (bus.m_valid && !m_ready) begin
                seen++;
                if (seen >= stall) m_ready = 1'b1;
            end
            if (bus.m_valid && m_ready) begin
                log_d.push_back(bus.m_data);
                log_l.push_back(bus.m_last);
                hs_n.push_back(n);
            end
            if (!busy) break;
        end
        start = 1'b0;
        chk("burst_ends", 64'(busy), 64'(0));
    endtask

    initial begin
        int d_seen;
        #12;
        chk("rst_rom_enb", 64'(bus.rom_enb), 64'(0));
        chk("rst_rom_addr", 64'(bus.rom_addr), 64'(0));
        chk("rst_out", 64'({bus.m_valid, bus.m_last, bus.m_data}), 64'(0));
        chk("rst_busy_done", 64'({busy, done}), 64'(0));
        @(negedge clk); #1; rst_n = 1'b1;

        burst(3'd0, 4'd8, 0, 1'b0);
        chk("full_data", pk_d(), 64'h01AA54FAE5985634);
        chk("full_last", pk_l(), 64'h01);
        chk("full_addr", pk_a(), 64'h01234567);
        chk("full_first_valid", 64'(first_v), 64'(3));
        chk("full_gaps", pk_g(), 64'h3333333);
        chk("full_busy_cycles", 64'(busy_n), 64'(25));
        chk("full_done", 64'({dones, done_n}), {32'd1, 32'd25});

        burst(3'd6, 4'd4, 0, 1'b0);
        chk("wrap_addr", pk_a(), 64'h6701);
        chk("wrap_data", pk_d(), 64'h563401AA);
        chk("wrap_last", pk_l(), 64'h1);
        chk("wrap_done", 64'(dones), 64'(1));

        burst(3'd2, 4'd2, 5, 1'b0);
        chk("bp_data", pk_d(), 64'h54FA);
        chk("bp_first_valid", 64'(first_v), 64'(3));
        chk("bp_gap", pk_g(), 64'h3);
        chk("bp_hs_first", 64'(hs_n[0]), 64'(7));
        chk("bp_rom_reads", 64'(n_enb), 64'(2));

        burst(3'd4, 4'd0, 0, 1'b0);
        chk("zero_words", 64'(log_d.size()), 64'(0));
        chk("zero_first_valid", 64'(first_v), 64'hFFFFFFFFFFFFFFFF);
        chk("zero_rom_reads", 64'(n_enb), 64'(0));
        chk("zero_done", 64'({dones, done_n}), {32'd1, 32'd1});
        chk("zero_busy", 64'(busy_n), 64'(1));

        burst(3'd0, 4'd3, 0, 1'b1);
        chk("spur_data", pk_d(), 64'h01AA54);
        chk("spur_addr", pk_a(), 64'h012);
        chk("spur_done", 64'(dones), 64'(1));

        @(negedge clk); #1;
        start = 1'b1; base_addr = 3'd0; len = 4'd8; m_ready = 1'b0;
        push_model(3'd0, 4'd8);
        @(negedge clk); #1; start = 1'b0;
        for (int i = 0; i < 20 && !bus.m_valid; i++) begin @(negedge clk); #1; end
        chk("rstb_valid_seen", 64'(bus.m_valid), 64'(1));
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstb_valid", 64'(bus.m_valid), 64'(0));
        chk("rstb_busy", 64'(busy), 64'(0));
        chk("rstb_rom_enb", 64'(bus.rom_enb), 64'(0));
        exp_d.delete(); exp_l.delete(); exp_a.delete();
        d_seen = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); #1; if (done) d_seen++; end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin @(negedge clk); #1; if (done) d_seen++; end
        chk("rstb_no_done", 64'(d_seen), 64'(0));

        burst(3'd5, 4'd1, 0, 1'b0);
        chk("post_rst_data", pk_d(), 64'h98);
        chk("post_rst_last", pk_l(), 64'h1);
        chk("post_rst_done", 64'(dones), 64'(1));

        repeat (2) @(negedge clk);
        #4;
        chk("model_drained", 64'(exp_d.size() + exp_a.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
